decoder_scan_sequencer: RTL and testbench



---
 rtl/decoder_scan_sequencer.sv | 144 ++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer for a 3-to-8 active-low-enable decoder: steps the select code through a
// programmable range with a fixed dwell per code and optional blanking between codes.
module decoder_scan_sequencer #(
  parameter int unsigned DWELL = 50,
  parameter int unsigned BLANK = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [2:0] first,
  input  logic [2:0] last,
  output logic [2:0] w,
  output logic       e,
  output logic       busy,
  output logic       step,
  output logic       done
);

  localparam logic [CNT_W-1:0] DwellEnd = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BlankEnd = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  typedef enum logic [1:0] {StIdle, StActive, StBlank} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       w_q, w_d;
  logic [2:0]       first_q, first_d;
  logic [2:0]       last_q, last_d;
  logic             mode_q, mode_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             step_q, step_d;
  logic             done_q, done_d;

  // Next-state qualifiers consumed by the output process
  logic             new_code;
  logic             pass_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      w_q     <= 3'd0;
      first_q <= 3'd0;
      last_q  <= 3'd0;
      mode_q  <= 1'b0;
      e_q     <= 1'b1;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      first_q <= first_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    first_d   = first_q;
    last_d    = last_q;
    mode_d    = mode_q;
    new_code  = 1'b0;
    pass_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          first_d  = first;
          last_d   = last;
          mode_d   = mode;
          w_d      = first;
          cnt_d    = '0;
          state_d  = StActive;
          new_code = 1'b1;
        end
      end
      StActive: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DwellEnd) begin
          cnt_d = '0;
          if (w_q == last_q && !mode_q) begin
            state_d   = StIdle;
            pass_done = 1'b1;
          end else begin
            // Address moves on the dwell boundary so it settles while the decoder is off
            w_d = (w_q == last_q) ? first_q : w_q + 3'd1;
            if (BLANK == 0) begin
              state_d  = StActive;
              new_code = 1'b1;
            end else begin
              state_d = StBlank;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StBlank: begin
        if (stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == BlankEnd) begin
          cnt_d    = '0;
          state_d  = StActive;
          new_code = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    e_d    = (state_d != StActive);
    busy_d = (state_d != StIdle);
    step_d = new_code;
    done_d = pass_done;
  end

  assign w    = w_q;
  assign e    = e_q;
  assign busy = busy_q;
  assign step = step_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: two instances (BLANK=2 and BLANK=0) share stimulus and are
// checked every cycle against an arithmetic schedule model plus literal expectations.
module tb_decoder_scan_sequencer;

  localparam int DW  = 4;
  localparam int BL0 = 2;
  localparam int BL1 = 0;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [2:0] first, last;

  logic [2:0] d_w[2];
  logic       d_e[2], d_busy[2], d_step[2], d_done[2];

  always #5 clk = ~clk;

  decoder_scan_sequencer #(.DWELL(DW), .BLANK(BL0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .first(first), .last(last),
    .w(d_w[0]), .e(d_e[0]), .busy(d_busy[0]), .step(d_step[0]), .done(d_done[0])
  );

  decoder_scan_sequencer #(.DWELL(DW), .BLANK(BL1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .first(first), .last(last),
    .w(d_w[1]), .e(d_e[1]), .busy(d_busy[1]), .step(d_step[1]), .done(d_done[1])
  );

  // ---------------- schedule model ----------------
  bit         model_valid = 1'b0;
  bit         m_run[2];
  int         m_t[2];
  logic [2:0] m_first[2], m_last[2];
  bit         m_mode[2];
  logic [2:0] exp_w[2];
  bit         exp_e[2], exp_busy[2], exp_step[2], exp_done[2];

  function automatic int range_len(input logic [2:0] f, input logic [2:0] l);
    return ((int'(l) - int'(f) + 8) % 8) + 1;
  endfunction

  // Output view t cycles after the first enabled cycle of a scan
  function automatic void view(input int t, input int blank, input logic [2:0] f,
                               input logic [2:0] l, output logic [2:0] vw, output bit ve,
                               output bit vs);
    int p, k, ph, n;
    p  = DW + blank;
    k  = t / p;
    ph = t % p;
    n  = range_len(f, l);
    if (ph < DW) begin
      vw = 3'(int'(f) + (k % n));
      ve = 1'b0;
      vs = (ph == 0);
    end else begin
      vw = 3'(int'(f) + ((k + 1) % n));
      ve = 1'b1;
      vs = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    model_valid <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      automatic int         bl = (i == 0) ? BL0 : BL1;
      automatic int         t;
      automatic logic [2:0] nw;
      automatic bit         ne, ns;
      if (rst) begin
        m_run[i]    <= 1'b0;
        exp_w[i]    <= 3'd0;
        exp_e[i]    <= 1'b1;
        exp_busy[i] <= 1'b0;
        exp_step[i] <= 1'b0;
        exp_done[i] <= 1'b0;
      end else if (!m_run[i]) begin
        exp_done[i] <= 1'b0;
        if (start && !stop) begin
          view(0, bl, first, last, nw, ne, ns);
          m_run[i]    <= 1'b1;
          m_t[i]      <= 0;
          m_first[i]  <= first;
          m_last[i]   <= last;
          m_mode[i]   <= mode;
          exp_w[i]    <= nw;
          exp_e[i]    <= ne;
          exp_busy[i] <= 1'b1;
          exp_step[i] <= ns;
        end else begin
          exp_e[i]    <= 1'b1;
          exp_busy[i] <= 1'b0;
          exp_step[i] <= 1'b0;
        end
      end else if (stop) begin
        m_run[i]    <= 1'b0;
        exp_e[i]    <= 1'b1;
        exp_busy[i] <= 1'b0;
        exp_step[i] <= 1'b0;
        exp_done[i] <= 1'b0;
      end else begin
        t = m_t[i] + 1;
        m_t[i] <= t;
        if (!m_mode[i] &&
            t == range_len(m_first[i], m_last[i]) * DW + (range_len(m_first[i], m_last[i]) - 1) * bl)
        begin
          m_run[i]    <= 1'b0;
          exp_w[i]    <= m_last[i];
          exp_e[i]    <= 1'b1;
          exp_busy[i] <= 1'b0;
          exp_step[i] <= 1'b0;
          exp_done[i] <= 1'b1;
        end else begin
          view(t, bl, m_first[i], m_last[i], nw, ne, ns);
          exp_w[i]    <= nw;
          exp_e[i]    <= ne;
          exp_busy[i] <= 1'b1;
          exp_step[i] <= ns;
          exp_done[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int rel;
  int busy_n[2], step_n[2], done_n[2], done_at[2], elow_run[2], elow_max[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    rel = -1;
    for (int i = 0; i < 2; i++) begin
      busy_n[i]   = 0;
      step_n[i]   = 0;
      done_n[i]   = 0;
      done_at[i]  = -1;
      elow_run[i] = 0;
      elow_max[i] = 0;
    end
  endtask

  // Compare at the falling edge, then return just after the next rising edge
  task automatic tick();
    @(negedge clk);
    rel++;
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d.w", i), 32'(d_w[i]), 32'(exp_w[i]));
        check($sformatf("dut%0d.e", i), 32'(d_e[i]), 32'(exp_e[i]));
        check($sformatf("dut%0d.busy", i), 32'(d_busy[i]), 32'(exp_busy[i]));
        check($sformatf("dut%0d.step", i), 32'(d_step[i]), 32'(exp_step[i]));
        check($sformatf("dut%0d.done", i), 32'(d_done[i]), 32'(exp_done[i]));
        if (d_step[i] && d_done[i]) check($sformatf("dut%0d.step_and_done", i), 1, 0);
        if (d_busy[i] === 1'b1) busy_n[i]++;
        if (d_step[i] === 1'b1) step_n[i]++;
        if (d_done[i] === 1'b1) begin
          done_n[i]++;
          done_at[i] = rel;
        end
        if (d_e[i] === 1'b0) begin
          elow_run[i]++;
          if (elow_run[i] > elow_max[i]) elow_max[i] = elow_run[i];
        end else begin
          elow_run[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_start(input logic [2:0] f, input logic [2:0] l, input logic md);
    first = f;
    last  = l;
    mode  = md;
    start = 1'b1;
    clear_counts();
    tick();
    start = 1'b0;
  endtask

  initial begin
    clear_counts();
    // 1. reset with random inputs
    rst   = 1'b1;
    start = 1'($urandom);
    stop  = 1'($urandom);
    mode  = 1'($urandom);
    first = 3'($urandom);
    last  = 3'($urandom);
    ticks(2);
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick();
    check("reset_w", 32'(d_w[0]), 0);
    check("reset_e", 32'(d_e[0]), 1);
    check("reset_busy", 32'(d_busy[0]), 0);
    check("reset_step", 32'(d_step[0]), 0);
    check("reset_done", 32'(d_done[0]), 0);
    ticks(2);

    // 2. full single pass 0..7
    pulse_start(3'd0, 3'd7, 1'b0);
    ticks(50);
    check("t2_busy_cycles", busy_n[0], 46);
    check("t2_steps", step_n[0], 8);
    check("t2_dones", done_n[0], 1);
    check("t2_done_cycle", done_at[0], 47);
    check("t2_w_after", 32'(d_w[0]), 7);
    check("t2_busy_cycles_noblank", busy_n[1], 32);

    // 3. wrapped range 6..1
    pulse_start(3'd6, 3'd1, 1'b0);
    ticks(30);
    check("t3_busy_cycles", busy_n[0], 22);
    check("t3_dones", done_n[0], 1);
    check("t3_busy_cycles_noblank", busy_n[1], 16);

    // 4. continuous 2..3, latched inputs changed mid-scan, stop in second dwell of code 3
    pulse_start(3'd2, 3'd3, 1'b1);
    first = 3'd7;
    last  = 3'd7;
    mode  = 1'b0;
    ticks(19);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("t4_stop_e", 32'(d_e[0]), 1);
    check("t4_stop_busy", 32'(d_busy[0]), 0);
    check("t4_stop_w_held", 32'(d_w[0]), 3);
    check("t4_dones", done_n[0], 0);
    check("t4_steps", step_n[0], 4);
    ticks(3);

    // 5. single code, start re-pulsed mid-dwell, then start+stop in idle
    pulse_start(3'd5, 3'd5, 1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(6);
    check("t5_busy_cycles", busy_n[0], 4);
    check("t5_steps", step_n[0], 1);
    check("t5_dones", done_n[0], 1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    check("t5_startstop_e", 32'(d_e[0]), 1);
    check("t5_startstop_busy", 32'(d_busy[0]), 0);

    // 6. reset while in BLANK
    pulse_start(3'd0, 3'd7, 1'b0);
    ticks(4);
    check("t6_in_blank_e", 32'(d_e[0]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t6_rst_w", 32'(d_w[0]), 0);
    check("t6_rst_e", 32'(d_e[0]), 1);
    check("t6_rst_busy", 32'(d_busy[0]), 0);
    ticks(10);
    check("t6_dones", done_n[0], 0);

    // 6b. back-to-back codes on the BLANK=0 instance
    pulse_start(3'd0, 3'd3, 1'b0);
    ticks(20);
    check("t6b_e_low_run", elow_max[1], 16);
    check("t6b_steps", step_n[1], 4);
    check("t6b_busy_cycles", busy_n[1], 16);
    check("t6b_done_cycle", done_at[1], 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
